// File: rtl/apb_axi_pkg.sv
// Shared types and constants for the AXI4-Lite to APB bridge: FSM states,
// APB/AXI response codes and the default ACCESS-phase timeout.
package apb_axi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    function automatic logic [1:0] resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_Lite.sv
// AXI4-Lite channel bundle with slave (bridge) and master (requester) views.
interface axi4_Lite #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
) (
    input logic aclk,
    input logic aresetn
);

    logic [addrWidth-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [dataWidth-1:0]   wdata;
    logic [dataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [addrWidth-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [dataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport axiSlave (
        input  aclk, aresetn,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport axiMaster (
        input  aclk, aresetn,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expired flags that timeoutCycles-1 stalled
// ACCESS cycles have already elapsed since the last clear.
module apb_timeout_counter
    import apb_axi_pkg::*;
#(
    parameter int timeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(timeoutCycles - 1);

    logic [7:0] count_r;
    logic       expired_r;

    // Count stalled cycles; expired is registered alongside the count it describes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_r   <= 8'd0;
            expired_r <= 1'b0;
        end else if (clear) begin
            count_r   <= 8'd0;
            expired_r <= 1'b0;
        end else if (enable) begin
            count_r   <= count_r + 8'd1;
            expired_r <= ((count_r + 8'd1) == LIMIT);
        end else begin
            count_r   <= count_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB master bridge with round-robin
// read/write arbitration and an ACCESS-phase timeout that answers SLVERR.
module axi_lite_apb_bridge
    import apb_axi_pkg::*;
#(
    parameter int dataWidth     = 32,
    parameter int addrWidth     = 32,
    parameter int timeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi4_Lite.axiSlave             axi,
    output logic [addrWidth-1:0]   paddr,
    output logic [2:0]             pprot,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [dataWidth-1:0]   pwdata,
    output logic [dataWidth/8-1:0] pstrb,
    input  logic [dataWidth-1:0]   prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int STRB_W = dataWidth / 8;

    state_e               state_r;
    logic                 last_was_write_r;
    logic                 awready_r;
    logic                 wready_r;
    logic                 arready_r;
    logic                 bvalid_r;
    logic                 rvalid_r;
    logic [1:0]           bresp_r;
    logic [1:0]           rresp_r;
    logic [dataWidth-1:0] rdata_r;

    logic wr_cand_s;
    logic rd_cand_s;
    logic grant_pending_s;
    logic grant_write_s;
    logic expired_s;
    logic tmo_clear_s;
    logic tmo_enable_s;

    // A write only counts once both address and data are offered together.
    assign wr_cand_s       = axi.awvalid && axi.wvalid;
    assign rd_cand_s       = axi.arvalid;
    assign grant_pending_s = awready_r || arready_r;
    assign grant_write_s   = wr_cand_s && (!rd_cand_s || !last_was_write_r);

    assign tmo_clear_s  = (state_r != ACCESS);
    assign tmo_enable_s = (state_r == ACCESS) && !pready;

    apb_timeout_counter #(
        .timeoutCycles(timeoutCycles)
    ) u_timeout (
        .aclk   (aclk),
        .aresetn(aresetn),
        .clear  (tmo_clear_s),
        .enable (tmo_enable_s),
        .expired(expired_s)
    );

    // Bridge FSM; the state register tracks the APB phase currently on the bus.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r          <= IDLE;
            last_was_write_r <= 1'b0;
            awready_r        <= 1'b0;
            wready_r         <= 1'b0;
            arready_r        <= 1'b0;
            bvalid_r         <= 1'b0;
            rvalid_r         <= 1'b0;
            bresp_r          <= RESP_OKAY;
            rresp_r          <= RESP_OKAY;
            rdata_r          <= {dataWidth{1'b0}};
            paddr            <= {addrWidth{1'b0}};
            pprot            <= 3'b000;
            psel             <= 1'b0;
            penable          <= 1'b0;
            pwrite           <= 1'b0;
            pwdata           <= {dataWidth{1'b0}};
            pstrb            <= {STRB_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_pending_s) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        arready_r <= 1'b0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        state_r   <= SETUP;
                    end else if (grant_write_s) begin
                        awready_r        <= 1'b1;
                        wready_r         <= 1'b1;
                        last_was_write_r <= 1'b1;
                        paddr            <= axi.awaddr;
                        pprot            <= axi.awprot;
                        pwrite           <= 1'b1;
                        pwdata           <= axi.wdata;
                        pstrb            <= axi.wstrb;
                    end else if (rd_cand_s) begin
                        arready_r        <= 1'b1;
                        last_was_write_r <= 1'b0;
                        paddr            <= axi.araddr;
                        pprot            <= axi.arprot;
                        pwrite           <= 1'b0;
                        pwdata           <= {dataWidth{1'b0}};
                        pstrb            <= {STRB_W{1'b0}};
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    // A timeout completes like an error response with zeroed read data.
                    if (pready || expired_s) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pwrite) begin
                            bvalid_r <= 1'b1;
                            bresp_r  <= pready ? resp_from_err(pslverr) : RESP_SLVERR;
                            state_r  <= WRESP;
                        end else begin
                            rvalid_r <= 1'b1;
                            rresp_r  <= pready ? resp_from_err(pslverr) : RESP_SLVERR;
                            rdata_r  <= pready ? prdata : {dataWidth{1'b0}};
                            state_r  <= RRESP;
                        end
                    end
                end
                WRESP: begin
                    if (axi.bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RRESP: begin
                    if (axi.rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    arready_r <= 1'b0;
                    bvalid_r  <= 1'b0;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign axi.awready = awready_r;
    assign axi.wready  = wready_r;
    assign axi.arready = arready_r;
    assign axi.bvalid  = bvalid_r;
    assign axi.bresp   = bresp_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rresp   = rresp_r;
    assign axi.rdata   = rdata_r;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Directed bench for axi_lite_apb_bridge: AXI requests queue expectations,
// an in-bench APB slave answers, and responses are checked against the queue.
module tb_axi_lite_apb_bridge;
    import apb_axi_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    axi4_Lite #(.dataWidth(32), .addrWidth(32)) axi (.aclk(aclk), .aresetn(aresetn));

    axi_lite_apb_bridge #(
        .dataWidth(32), .addrWidth(32), .timeoutCycles(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .axi(axi.axiSlave),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        zero_wait;
        logic        hang;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cfg_waits;
    logic        cfg_err;
    logic        cfg_hang;
    logic [31:0] cfg_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [2:0] p, input logic with_w);
        exp_t e;
        axi.awaddr = a; axi.awprot = p; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = with_w;
        e.is_write = 1'b1; e.addr = a; e.wdata = d; e.strb = s; e.prot = p;
        e.resp = (cfg_err || cfg_hang) ? 2'b10 : 2'b00;
        e.rdata = 32'h0;
        e.zero_wait = (cfg_waits == 0) && !cfg_hang;
        e.hang = cfg_hang;
        sb_q.push_back(e);
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [2:0] p);
        exp_t e;
        axi.araddr = a; axi.arprot = p; axi.arvalid = 1'b1;
        e.is_write = 1'b0; e.addr = a; e.wdata = 32'h0; e.strb = 4'h0; e.prot = p;
        e.resp = (cfg_err || cfg_hang) ? 2'b10 : 2'b00;
        e.rdata = cfg_hang ? 32'h0 : cfg_rdata;
        e.zero_wait = (cfg_waits == 0) && !cfg_hang;
        e.hang = cfg_hang;
        sb_q.push_back(e);
    endtask

    // Runs cycles until every queued request has been answered and acknowledged.
    task automatic run_engine(input int max_cyc);
        exp_t e;
        int   cyc = 0;
        int   acc_cyc = -100;
        int   setup_cyc = -100;
        int   access_n = 0;
        int   hold = 0;
        bit   aw_hs = 1'b0;
        bit   ar_hs = 1'b0;
        bit   resp_hs = 1'b0;
        bit   resp_seen = 1'b0;
        bit   done = 1'b0;
        while (!done && cyc < max_cyc) begin
            tick();
            cyc++;
            if (aw_hs) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; aw_hs = 1'b0; end
            if (ar_hs) begin axi.arvalid = 1'b0; ar_hs = 1'b0; end
            if (resp_hs) begin
                axi.bready = 1'b0; axi.rready = 1'b0; resp_hs = 1'b0;
                chk("valid_clear_after_hs", 64'({axi.bvalid, axi.rvalid}), 64'd0);
                chk("no_accept_right_after_hs", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
            end
            if (axi.awready) begin
                chk("aw_w_ready_together", 64'({axi.awvalid, axi.wvalid, axi.wready}), 64'h7);
                acc_cyc = cyc; aw_hs = 1'b1;
            end
            if (axi.arready) begin acc_cyc = cyc; ar_hs = 1'b1; end
            if (psel && !penable) begin
                setup_cyc = cyc; access_n = 0;
                chk("setup_after_accept", 64'(cyc), 64'(acc_cyc + 1));
                chk("sb_nonempty_at_setup", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    chk("setup_paddr", 64'(paddr), 64'(sb_q[0].addr));
                    chk("setup_pwrite", 64'(pwrite), 64'(sb_q[0].is_write));
                    chk("setup_pwdata", 64'(pwdata), 64'(sb_q[0].wdata));
                    chk("setup_pstrb_pprot", 64'({pstrb, pprot}), 64'({sb_q[0].strb, sb_q[0].prot}));
                end
                // Junk completion during SETUP that the bridge must ignore.
                pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
            end else if (psel && penable) begin
                if (cyc == setup_cyc + 1 && sb_q.size() != 0) begin
                    chk("access_paddr_stable", 64'(paddr), 64'(sb_q[0].addr));
                    chk("access_pwdata_stable", 64'({pwdata, pstrb}), 64'({sb_q[0].wdata, sb_q[0].strb}));
                end
                pready  = !cfg_hang && (access_n >= cfg_waits);
                pslverr = pready && cfg_err;
                prdata  = pready ? cfg_rdata : 32'hBAD0_BAD0;
                access_n++;
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
            if (axi.bvalid || axi.rvalid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1; hold = 2;
                    chk("sb_nonempty_at_resp", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) e = sb_q.pop_front();
                    chk("resp_kind", 64'({axi.bvalid, axi.rvalid}), 64'({e.is_write, !e.is_write}));
                    chk("apb_idle_at_resp", 64'({psel, penable}), 64'd0);
                    if (e.zero_wait) chk("latency_accept_to_resp", 64'(cyc), 64'(acc_cyc + 3));
                    if (e.hang) chk("timeout_access_cycles", 64'(access_n), 64'd16);
                end
                if (e.is_write) begin
                    chk("bresp", 64'(axi.bresp), 64'(e.resp));
                end else begin
                    chk("rresp", 64'(axi.rresp), 64'(e.resp));
                    chk("rdata", 64'(axi.rdata), 64'(e.rdata));
                end
                if (hold > 0) begin
                    hold--;
                end else begin
                    if (axi.bvalid) axi.bready = 1'b1;
                    else axi.rready = 1'b1;
                    resp_hs = 1'b1; resp_seen = 1'b0;
                end
            end
            done = (sb_q.size() == 0) && !resp_seen && !resp_hs && !axi.awvalid && !axi.arvalid;
        end
        chk("engine_completed", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        bit hs;
        aresetn = 1'b0;
        axi.awaddr = 32'h0; axi.awprot = 3'b000; axi.awvalid = 1'b0;
        axi.wdata = 32'h0; axi.wstrb = 4'h0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = 32'h0; axi.arprot = 3'b000; axi.arvalid = 1'b0; axi.rready = 1'b0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        cfg_waits = 0; cfg_err = 1'b0; cfg_hang = 1'b0; cfg_rdata = 32'h0;
        tick();
        tick();
        chk("rst_apb_ctrl", 64'({psel, penable, pwrite}), 64'd0);
        chk("rst_axi_ctrl", 64'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 64'd0);
        chk("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
        chk("rst_pstrb_pprot_resp", 64'({pstrb, pprot, axi.bresp, axi.rresp}), 64'd0);
        chk("rst_rdata", 64'(axi.rdata), 64'd0);
        aresetn = 1'b1;
        tick();

        // Zero-wait write.
        issue_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b1);
        run_engine(40);

        // Read with three wait states.
        cfg_waits = 3; cfg_rdata = 32'h1234_5678;
        issue_read(32'h0000_0020, 3'b010);
        run_engine(40);

        // Error completions, partial strobes and non-zero prot.
        cfg_waits = 0; cfg_err = 1'b1; cfg_rdata = 32'h0BAD_CAFE;
        issue_write(32'h0000_0104, 32'h0102_0304, 4'h5, 3'b011, 1'b1);
        run_engine(40);
        cfg_waits = 1;
        issue_read(32'h0000_0108, 3'b101);
        run_engine(40);

        // Simultaneous read and write, twice: write wins each time.
        cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'h5555_AAAA;
        issue_write(32'h0000_0200, 32'h1111_2222, 4'hC, 3'b001, 1'b1);
        issue_read(32'h0000_0204, 3'b000);
        run_engine(60);
        cfg_rdata = 32'h7777_8888;
        issue_write(32'h0000_0300, 32'h3333_4444, 4'h3, 3'b000, 1'b1);
        issue_read(32'h0000_0304, 3'b100);
        run_engine(60);

        // Address alone for five cycles must not be accepted.
        issue_write(32'h0000_0400, 32'hFEED_FACE, 4'hF, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("aw_alone_no_ready", 64'({axi.awready, axi.wready}), 64'd0);
        end
        axi.wvalid = 1'b1;
        run_engine(40);

        // Stalled slave: write and read both time out.
        cfg_hang = 1'b1;
        issue_write(32'h0000_0500, 32'hABCD_EF01, 4'hF, 3'b000, 1'b1);
        run_engine(60);
        issue_read(32'h0000_0504, 3'b000);
        run_engine(60);

        // Reset during ACCESS abandons the transaction.
        issue_write(32'h0000_0600, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b1);
        n = 0; hs = 1'b0;
        while (!(psel && penable) && n < 20) begin
            tick();
            n++;
            if (hs) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; end
            hs = axi.awready;
        end
        chk("reached_access_before_reset", 64'(psel && penable), 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_apb", 64'({psel, penable}), 64'd0);
        chk("async_rst_axi", 64'({axi.bvalid, axi.rvalid, axi.awready, axi.arready}), 64'd0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        sb_q.delete();
        pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        cfg_hang = 1'b0; cfg_waits = 1; cfg_rdata = 32'hA5A5_0F0F;
        issue_read(32'h0000_0044, 3'b001);
        run_engine(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
